// File: rtl/cam_read_if.sv
// Camera-side inputs and frame-buffer write outputs of the camera capture block.
interface cam_read_if #(
    parameter int unsigned AW = 15
);
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_px_addr;
    logic [7:0]    mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          overflow;

    modport master (
        output vsync, href, px_data,
        input  mem_px_addr, mem_px_data, px_wr, frame_done, overflow
    );

    modport slave (
        input  vsync, href, px_data,
        output mem_px_addr, mem_px_data, px_wr, frame_done, overflow
    );
endinterface

// File: rtl/cam_read.sv
// Captures an RGB565 camera byte stream, converts to RGB332 and writes it
// sequentially into a IMG_W x IMG_H frame buffer.
module cam_read #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned AW    = 15
) (
    input logic       pclk,
    input logic       rst,
    cam_read_if.slave cam
);
    localparam int unsigned CW = $clog2(IMG_W + 1);
    localparam int unsigned RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_LIM  = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_LIM  = RW'(IMG_H);
    localparam logic [AW-1:0] ADDR_MAX = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        IDLE_LINE,
        BYTE1,
        BYTE2
    } state_e;

    state_e        state_q, state_d;
    logic          vsync_q;
    logic [7:0]    byte1_q, byte1_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          wrote_q, wrote_d;

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q <= WAIT_FRAME;
            vsync_q <= 1'b0;
            byte1_q <= 8'd0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            data_q  <= 8'd0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wrote_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= cam.vsync;
            byte1_q <= byte1_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            wrote_q <= wrote_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte1_d = byte1_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        wrote_d = wrote_q;

        // Address moves on only after the write it labels, and saturates at the last pixel.
        if (wr_q && (addr_q < ADDR_MAX)) begin
            addr_d = addr_q + AW'(1);
        end

        if ((state_q != WAIT_FRAME) && cam.vsync) begin
            state_d = WAIT_FRAME;
            done_d  = wrote_q;
        end else begin
            case (state_q)
                WAIT_FRAME: begin
                    if (vsync_q && !cam.vsync) begin
                        state_d = IDLE_LINE;
                        col_d   = '0;
                        row_d   = '0;
                        addr_d  = '0;
                        ovf_d   = 1'b0;
                        wrote_d = 1'b0;
                    end
                end
                IDLE_LINE: begin
                    if (cam.href) begin
                        byte1_d = cam.px_data;
                        state_d = BYTE2;
                    end
                end
                BYTE1: begin
                    if (cam.href) begin
                        byte1_d = cam.px_data;
                        state_d = BYTE2;
                    end else begin
                        if (row_q < ROW_LIM) row_d = row_q + RW'(1);
                        col_d   = '0;
                        state_d = IDLE_LINE;
                    end
                end
                BYTE2: begin
                    if (cam.href) begin
                        state_d = BYTE1;
                        if ((col_q < COL_LIM) && (row_q < ROW_LIM)) begin
                            data_d  = {byte1_q[7:5], byte1_q[2:0], cam.px_data[4:3]};
                            wr_d    = 1'b1;
                            wrote_d = 1'b1;
                            col_d   = col_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        // Line ended mid-pixel: the lone byte1 is dropped.
                        if (row_q < ROW_LIM) row_d = row_q + RW'(1);
                        col_d   = '0;
                        state_d = IDLE_LINE;
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    assign cam.mem_px_addr = addr_q;
    assign cam.mem_px_data = data_q;
    assign cam.px_wr       = wr_q;
    assign cam.frame_done  = done_q;
    assign cam.overflow    = ovf_q;
endmodule

// File: tb/tb_cam_read.sv
// Randomized scoreboard bench for cam_read: a frame-level model predicts every
// frame-buffer write and frame_done pulse; a monitor checks what the DUT emits.
module tb_cam_read;
    localparam int unsigned IMG_W = 160;
    localparam int unsigned IMG_H = 120;
    localparam int unsigned AW    = 15;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic pclk = 1'b0;
    logic rst;
    cam_read_if #(.AW(AW)) cam ();

    cam_read #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .pclk (pclk),
        .rst  (rst),
        .cam  (cam)
    );

    always #5 pclk = ~pclk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   done_cnt = 0;
    int   wr_cnt   = 0;

    int m_addr, m_row, exp_done;
    bit m_ovf, m_wrote;

    function automatic void chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endfunction

    // RGB565 -> RGB332 by arithmetic on the two bytes.
    function automatic int conv(int b1, int b2);
        return (b1 / 32) * 32 + (b1 % 8) * 4 + (b2 / 8) % 4;
    endfunction

    always @(negedge pclk) begin
        if (cam.px_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_px_wr_addr", longint'(cam.mem_px_addr), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", longint'(cam.mem_px_addr), e.addr);
                chk("wr_data", longint'(cam.mem_px_data), e.data);
            end
        end
        if (cam.frame_done) done_cnt++;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic model_line(input bq_t b);
        for (int c = 0; c < b.size() / 2; c++) begin
            if (c < int'(IMG_W) && m_row < int'(IMG_H)) begin
                exp_t e;
                e.addr = m_addr;
                e.data = conv(int'(b[2*c]), int'(b[2*c+1]));
                exp_q.push_back(e);
                m_addr++;
                m_wrote = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_row++;
    endtask

    task automatic drive_line(input bq_t b);
        cam.href = 1'b1;
        foreach (b[i]) begin
            cam.px_data = b[i];
            tick();
        end
        cam.href    = 1'b0;
        cam.px_data = 8'd0;
        repeat (3) tick();
    endtask

    task automatic send_line(input bq_t b);
        model_line(b);
        drive_line(b);
    endtask

    task automatic rand_line(input int nbytes);
        bq_t b;
        for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom));
        send_line(b);
    endtask

    task automatic start_frame();
        cam.vsync = 1'b1;
        repeat (3) tick();
        cam.vsync = 1'b0;
        m_addr  = 0;
        m_row   = 0;
        m_ovf   = 1'b0;
        m_wrote = 1'b0;
        repeat (2) tick();
    endtask

    task automatic end_frame(input string tag);
        cam.vsync = 1'b1;
        repeat (3) tick();
        if (m_wrote) exp_done++;
        m_wrote = 1'b0;
        chk({tag, "_frame_done_count"}, done_cnt, exp_done);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
        chk({tag, "_overflow"}, longint'(cam.overflow), longint'(m_ovf));
    endtask

    initial begin
        bq_t b;
        rst         = 1'b0;
        cam.vsync   = 1'b0;
        cam.href    = 1'b0;
        cam.px_data = 8'd0;
        exp_done    = 0;
        m_addr = 0; m_row = 0; m_ovf = 1'b0; m_wrote = 1'b0;
        repeat (3) tick();
        @(negedge pclk);
        chk("rst_addr", longint'(cam.mem_px_addr), 0);
        chk("rst_data", longint'(cam.mem_px_data), 0);
        chk("rst_wr", longint'(cam.px_wr), 0);
        chk("rst_done", longint'(cam.frame_done), 0);
        chk("rst_ovf", longint'(cam.overflow), 0);
        rst = 1'b1;
        tick();

        // No vsync edge yet: a line must be ignored.
        b = {};
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
        drive_line(b);
        chk("no_capture_before_vsync", wr_cnt, 0);

        // Single known pixel.
        start_frame();
        b = {8'hF8, 8'h1F};
        send_line(b);
        chk("s1_data", longint'(cam.mem_px_data), 8'hE3);
        chk("s1_addr_after", longint'(cam.mem_px_addr), 1);
        end_frame("s1");

        // Odd byte count lines: partial byte dropped, next line restarts at column 0.
        start_frame();
        rand_line(3);
        rand_line(5);
        chk("odd_writes_seen", wr_cnt, 1 + 1 + 2);
        end_frame("odd");

        // Random short frames.
        for (int f = 0; f < 4; f++) begin
            start_frame();
            for (int l = 0; l < int'($urandom_range(1, 6)); l++) rand_line(int'($urandom_range(1, 24)));
            end_frame("rand");
        end

        // Over-long line then a normal one; overflow stays set until next frame start.
        start_frame();
        rand_line(330);
        rand_line(20);
        chk("long_addr_after", longint'(cam.mem_px_addr), 170);
        end_frame("long");
        start_frame();
        chk("ovf_cleared_on_start", longint'(cam.overflow), 0);
        end_frame("empty");

        // Too many lines.
        start_frame();
        for (int l = 0; l < int'(IMG_H) + 2; l++) rand_line(4);
        end_frame("rows");

        // Full frame.
        start_frame();
        for (int l = 0; l < int'(IMG_H); l++) rand_line(2 * int'(IMG_W));
        chk("full_last_addr", longint'(cam.mem_px_addr), IMG_W * IMG_H - 1);
        chk("full_model_count", m_addr, IMG_W * IMG_H);
        end_frame("full");

        // Reset during BYTE2 after a few written pixels.
        start_frame();
        rand_line(8);
        cam.href    = 1'b1;
        cam.px_data = 8'($urandom);
        tick();
        cam.px_data = 8'($urandom);
        rst         = 1'b0;
        tick();
        @(negedge pclk);
        chk("midrst_addr", longint'(cam.mem_px_addr), 0);
        chk("midrst_data", longint'(cam.mem_px_data), 0);
        chk("midrst_wr", longint'(cam.px_wr), 0);
        chk("midrst_ovf", longint'(cam.overflow), 0);
        rst      = 1'b1;
        cam.href = 1'b0;
        m_wrote  = 1'b0;
        tick();
        b = {};
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        drive_line(b);
        chk("midrst_pending", exp_q.size(), 0);
        start_frame();
        rand_line(6);
        end_frame("after_rst");

        // vsync while href high after 10 pixels.
        start_frame();
        b = {};
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        model_line(b);
        cam.href = 1'b1;
        foreach (b[i]) begin
            cam.px_data = b[i];
            tick();
        end
        cam.vsync = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cam.px_data = 8'($urandom);
            tick();
        end
        cam.href = 1'b0;
        end_frame("abort");
        start_frame();
        rand_line(4);
        end_frame("post_abort");

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cam_read.md
CAM_READ -- requirements
Module: cam_read

Interface
REQ-001 Parameter IMG_W, default 160, active pixels per line stored.
REQ-002 Parameter IMG_H, default 120, active lines per frame stored.
REQ-003 Parameter AW, default 15, memory address width; IMG_W*IMG_H SHALL fit in AW bits.
REQ-004 Port pclk  input  1  camera pixel clock, the only clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low; sampled on the rising edge of pclk.
REQ-006 Port vsync  input  1  camera frame sync; high = vertical blanking.
REQ-007 Port href  input  1  camera line valid; high = data bytes valid.
REQ-008 Port px_data  input  8  camera byte stream, RGB565, high byte first.
REQ-009 Port mem_px_addr  output  AW  write address into the frame buffer.
REQ-010 Port mem_px_data  output  8  RGB332 pixel to write.
REQ-011 Port px_wr  output  1  one-cycle write strobe for the frame buffer.
REQ-012 Port frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-013 Port overflow  output  1  sticky flag: camera delivered more pixels or lines than IMG_W/IMG_H.

Function
REQ-014 The FSM SHALL have states WAIT_FRAME, IDLE_LINE, BYTE1, BYTE2.
REQ-015 WAIT_FRAME: stay while vsync=1 or until a vsync 1->0 edge has been seen; on that edge go to IDLE_LINE with column=0, row=0, mem_px_addr=0.
REQ-016 IDLE_LINE: on href=1 sample px_data as byte1 and go to BYTE2.
REQ-017 BYTE2: if href=1, sample byte2, form the pixel, go to BYTE1; if href=0, discard partial byte1, increment row, go to IDLE_LINE.
REQ-018 BYTE1: if href=1 sample byte1, go to BYTE2; if href=0 increment row, reset column to 0, go to IDLE_LINE.
REQ-019 Pixel conversion: mem_px_data = {byte1[7:5], byte1[2:0], byte2[4:3]} (R3 G3 B2).
REQ-020 px_wr SHALL pulse high for exactly one pclk, the cycle after byte2 is sampled, with mem_px_addr and mem_px_data stable and valid in that same cycle.
REQ-021 After each px_wr, column increments and mem_px_addr increments by 1; latency byte2-sample to px_wr = 1 cycle.
REQ-022 Pixels with column >= IMG_W or row >= IMG_H SHALL NOT assert px_wr; mem_px_addr SHALL NOT advance; overflow SHALL set to 1.
REQ-023 mem_px_addr SHALL never exceed IMG_W*IMG_H-1 and SHALL never wrap.
REQ-024 vsync=1 in any state other than WAIT_FRAME: abort any partial pixel, pulse frame_done for one cycle if at least one px_wr occurred in this frame, go to WAIT_FRAME.
REQ-025 overflow clears only on reset or on the vsync 1->0 edge that starts the next frame.
REQ-026 vsync and href change simultaneously (vsync 1, href 1): vsync takes priority; no byte sampled.
REQ-027 No px_wr and no frame_done SHALL occur in WAIT_FRAME.

Reset
REQ-028 rst=0 at a rising pclk edge SHALL force state WAIT_FRAME, mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, overflow=0, column=0, row=0, stored vsync-edge history cleared.
REQ-029 Reset asserted mid-line or mid-pixel SHALL drop the partial pixel with no px_wr in or after the reset cycle; capture resumes only after a fresh vsync 1->0 edge.

Verification
REQ-030 Scenario: after reset, vsync 1->0, one line of href=1 with bytes 0xF8,0x1F -> one px_wr, mem_px_addr=0, mem_px_data=0xE3.
REQ-031 Scenario: full 160x120 frame, 320 bytes/line -> 19200 px_wr, final address 19199, frame_done single pulse on next vsync=1, overflow=0.
REQ-032 Scenario: line of 330 bytes (165 pixels) -> only 160 px_wr for that line, address continues at line*160 next line, overflow=1 until next frame start.
REQ-033 Scenario: href drops after odd byte count (3 bytes) -> exactly 1 px_wr, partial byte discarded, next line starts at column 0.
REQ-034 Scenario: rst=0 for one cycle during BYTE2 -> no px_wr, all outputs 0 next cycle, no capture until vsync 1->0.
REQ-035 Scenario: vsync=1 while href=1 mid-line after 10 pixels -> frame_done pulse once, no further px_wr, next frame starts at address 0.
